// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the RISC-V load/store unit.
package riscv_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_e;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    localparam int BE_W = 4;

    // Halfwords need an even address, words a 4-byte aligned one; bytes never fault.
    function automatic logic is_misaligned(input logic [2:0] funct, input logic [1:0] addr_lo);
        logic result;
        case (funct[1:0])
            2'b00:   result = 1'b0;
            2'b01:   result = addr_lo[0];
            default: result = |addr_lo;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables, store replication, load shift/extend.
module lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [2:0]      funct,
    input  logic [1:0]      addr_lo,
    input  logic [31:0]     wr_data,
    input  logic [31:0]     rdata,
    output logic [BE_W-1:0] be,
    output logic [31:0]     wdata,
    output logic [31:0]     load_data
);

    logic [31:0] shifted_s;

    // Byte enables and store data replicated into every lane the access may hit.
    always_comb begin
        be    = 4'b1111;
        wdata = wr_data;
        case (funct[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{wr_data[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << addr_lo;
                wdata = {2{wr_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = wr_data;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0, then sign- or zero-extend.
    always_comb begin
        shifted_s = rdata >> {addr_lo, 3'b000};
        case (funct)
            F_B:     load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F_H:     load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F_W:     load_data = rdata;
            F_BU:    load_data = {24'h000000, shifted_s[7:0]};
            F_HU:    load_data = {16'h0000, shifted_s[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one outstanding bus access, stalls the core until it completes.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [31:0]     addr,
    input  logic [31:0]     wr_data,
    input  logic [2:0]      funct,
    output logic [31:0]     rd_data,
    output logic            stall,
    output logic            misalign_err,
    output logic            timeout_err,
    output logic            bus_req_valid,
    input  logic            bus_req_ready,
    output logic            bus_we,
    output logic [31:0]     bus_addr,
    output logic [BE_W-1:0] bus_be,
    output logic [31:0]     bus_wdata,
    input  logic            bus_rsp_valid,
    input  logic [31:0]     bus_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e         state_r;
    lsu_state_e         state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [31:0]        addr_r;
    logic [31:0]        wdata_r;
    logic [2:0]         funct_r;
    logic               we_r;
    logic [31:0]        rd_data_r;

    logic               mem_op_s;
    logic               start_s;
    logic               capture_s;
    logic               stall_s;
    logic               misalign_s;
    logic               timeout_s;
    logic               req_valid_s;
    logic [31:0]        load_data_s;

    assign mem_op_s = mem_read | mem_write;

    // Next-state and per-state control decode.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        capture_s   = 1'b0;
        stall_s     = 1'b0;
        misalign_s  = 1'b0;
        timeout_s   = 1'b0;
        req_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mem_op_s) begin
                    stall_s = 1'b1;
                    if (is_misaligned(funct, addr[1:0])) begin
                        misalign_s  = 1'b1;
                        state_nxt_s = ST_DONE;
                    end else begin
                        start_s     = 1'b1;
                        state_nxt_s = ST_REQ;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                stall_s     = 1'b1;
                req_valid_s = 1'b1;
                if (bus_req_ready) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                stall_s = 1'b1;
                if (bus_rsp_valid) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_DONE;
                end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, access latches, WAIT counter and load result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            addr_r    <= 32'h0000_0000;
            wdata_r   <= 32'h0000_0000;
            funct_r   <= 3'b000;
            we_r      <= 1'b0;
            rd_data_r <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            if (start_s) begin
                addr_r  <= addr;
                wdata_r <= wr_data;
                funct_r <= funct;
                we_r    <= mem_write;
            end else begin
                addr_r  <= addr_r;
                wdata_r <= wdata_r;
                funct_r <= funct_r;
                we_r    <= we_r;
            end
            // Counter is zero on every WAIT entry since it idles at zero elsewhere.
            if (state_r == ST_WAIT) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= '0;
            end
            // Stores never disturb the last load result.
            if (capture_s && !we_r) begin
                rd_data_r <= load_data_s;
            end else if (timeout_s && !we_r) begin
                rd_data_r <= 32'h0000_0000;
            end else begin
                rd_data_r <= rd_data_r;
            end
        end
    end

    lsu_align u_align (
        .funct     (funct_r),
        .addr_lo   (addr_r[1:0]),
        .wr_data   (wdata_r),
        .rdata     (bus_rdata),
        .be        (bus_be),
        .wdata     (bus_wdata),
        .load_data (load_data_s)
    );

    // Decoded outputs are held quiet while reset is asserted.
    assign rd_data       = rd_data_r;
    assign stall         = stall_s & ~reset;
    assign misalign_err  = misalign_s & ~reset;
    assign timeout_err   = timeout_s & ~reset;
    assign bus_req_valid = req_valid_s & ~reset;
    assign bus_we        = we_r;
    assign bus_addr      = {addr_r[31:2], 2'b00};

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed loads/stores, faults and reset abort.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [2:0]  funct;
    logic [31:0] rd_data;
    logic        stall;
    logic        misalign_err;
    logic        timeout_err;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;

    riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .addr          (addr),
        .wr_data       (wr_data),
        .funct         (funct),
        .rd_data       (rd_data),
        .stall         (stall),
        .misalign_err  (misalign_err),
        .timeout_err   (timeout_err),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_be        (bus_be),
        .bus_wdata     (bus_wdata),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rdata     (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Move to the next cycle: inputs change just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Load with immediate ready and response; the expected result goes to the scoreboard.
    task automatic do_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rdata,
                           input logic [31:0] exp_rd, input logic [3:0] exp_be);
        logic [31:0] exp;
        exp_q.push_back(exp_rd);
        mem_read = 1'b1; addr = a; funct = f; bus_req_ready = 1'b1;
        sample();
        check_value("ld_c0_stall", {31'd0, stall}, 32'd1);
        check_value("ld_c0_valid", {31'd0, bus_req_valid}, 32'd0);
        tick();
        sample();
        check_value("ld_c1_valid", {31'd0, bus_req_valid}, 32'd1);
        check_value("ld_c1_addr", bus_addr, {a[31:2], 2'b00});
        check_value("ld_c1_be", {28'd0, bus_be}, {28'd0, exp_be});
        check_value("ld_c1_we", {31'd0, bus_we}, 32'd0);
        check_value("ld_c1_stall", {31'd0, stall}, 32'd1);
        tick();
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rdata = rdata;
        sample();
        check_value("ld_c2_stall", {31'd0, stall}, 32'd1);
        tick();
        bus_rsp_valid = 1'b0; bus_rdata = 32'h0; mem_read = 1'b0;
        sample();
        check_value("ld_c3_stall", {31'd0, stall}, 32'd0);
        if (exp_q.size() == 0) begin
            check_value("ld_sb_empty", 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            check_value("ld_rd_data", rd_data, exp);
            last_rd = exp;
        end
        tick();
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] rdata;
        logic [31:0] exp_rd;
        logic [3:0]  exp_be;
    } load_vec_t;

    load_vec_t loads[6];

    initial begin
        loads[0] = '{3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b1111};
        loads[1] = '{3'b000, 32'h0000_0103, 32'h8000_0000, 32'hFFFF_FF80, 4'b1000};
        loads[2] = '{3'b100, 32'h0000_0103, 32'h8000_0000, 32'h0000_0080, 4'b1000};
        loads[3] = '{3'b001, 32'h0000_0412, 32'h8001_1234, 32'hFFFF_8001, 4'b1100};
        loads[4] = '{3'b101, 32'h0000_0410, 32'h8001_F234, 32'h0000_F234, 4'b0011};
        loads[5] = '{3'b000, 32'h0000_0501, 32'h0000_7F00, 32'h0000_007F, 4'b0010};

        reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = 32'h0; wr_data = 32'h0;
        funct = 3'b000; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
        last_rd = 32'h0;
        tick();
        tick();
        sample();
        check_value("rst_rd_data", rd_data, 32'h0);
        check_value("rst_valid", {31'd0, bus_req_valid}, 32'd0);
        check_value("rst_errs", {30'd0, misalign_err, timeout_err}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        sample();
        check_value("idle_stall", {31'd0, stall}, 32'd0);
        tick();

        for (int i = 0; i < 6; i++) begin
            do_load(loads[i].f, loads[i].a, loads[i].rdata, loads[i].exp_rd, loads[i].exp_be);
        end

        // SH with ready held low for three cycles; read and write both asserted acts as store.
        mem_write = 1'b1; mem_read = 1'b1; addr = 32'h0000_0202; wr_data = 32'h1234_ABCD; funct = 3'b001;
        sample();
        check_value("st_c0_stall", {31'd0, stall}, 32'd1);
        tick();
        mem_read = 1'b0; addr = 32'hFFFF_FFFF; wr_data = 32'h0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) bus_req_ready = 1'b1;
            sample();
            check_value("st_valid", {31'd0, bus_req_valid}, 32'd1);
            check_value("st_addr", bus_addr, 32'h0000_0200);
            check_value("st_be", {28'd0, bus_be}, 32'h0000_000C);
            check_value("st_wdata", bus_wdata, 32'hABCD_ABCD);
            check_value("st_we", {31'd0, bus_we}, 32'd1);
            tick();
        end
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rdata = 32'h5A5A_5A5A;
        sample();
        check_value("st_wait_valid", {31'd0, bus_req_valid}, 32'd0);
        tick();
        bus_rsp_valid = 1'b0; mem_write = 1'b0;
        sample();
        check_value("st_done_stall", {31'd0, stall}, 32'd0);
        check_value("st_rd_keep", rd_data, last_rd);
        tick();

        // Misaligned LW.
        mem_read = 1'b1; addr = 32'h0000_0101; funct = 3'b010;
        sample();
        check_value("mis_c0_pulse", {31'd0, misalign_err}, 32'd1);
        check_value("mis_c0_valid", {31'd0, bus_req_valid}, 32'd0);
        tick();
        mem_read = 1'b0;
        sample();
        check_value("mis_c1_stall", {31'd0, stall}, 32'd0);
        check_value("mis_c1_pulse", {31'd0, misalign_err}, 32'd0);
        check_value("mis_c1_valid", {31'd0, bus_req_valid}, 32'd0);
        check_value("mis_rd_keep", rd_data, last_rd);
        tick();
        sample();
        check_value("mis_c2_valid", {31'd0, bus_req_valid}, 32'd0);
        tick();

        // Reset while in WAIT, then a late response.
        mem_read = 1'b1; addr = 32'h0000_0100; funct = 3'b010; bus_req_ready = 1'b1;
        tick();
        tick();
        bus_req_ready = 1'b0;
        sample();
        check_value("rw_wait_stall", {31'd0, stall}, 32'd1);
        tick();
        reset = 1'b1; mem_read = 1'b0;
        sample();
        check_value("rw_rst_errs", {30'd0, misalign_err, timeout_err}, 32'd0);
        check_value("rw_rst_valid", {31'd0, bus_req_valid}, 32'd0);
        tick();
        reset = 1'b0; bus_rsp_valid = 1'b1; bus_rdata = 32'h5555_5555;
        sample();
        check_value("rw_rd_zero", rd_data, 32'h0);
        check_value("rw_stall", {31'd0, stall}, 32'd0);
        check_value("rw_errs", {30'd0, misalign_err, timeout_err}, 32'd0);
        tick();
        bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
        sample();
        check_value("rw_rd_late", rd_data, 32'h0);
        check_value("rw_valid", {31'd0, bus_req_valid}, 32'd0);
        tick();
        do_load(3'b010, 32'h0000_0600, 32'h0BAD_F00D, 32'h0BAD_F00D, 4'b1111);

        // LW with no response: timeout after 4 WAIT cycles.
        mem_read = 1'b1; addr = 32'h0000_0300; funct = 3'b010; bus_req_ready = 1'b1;
        tick();
        tick();
        bus_req_ready = 1'b0;
        for (int w = 0; w < 4; w++) begin
            sample();
            check_value("to_stall", {31'd0, stall}, 32'd1);
            check_value("to_pulse", {31'd0, timeout_err}, (w == 3) ? 32'd1 : 32'd0);
            tick();
        end
        mem_read = 1'b0;
        sample();
        check_value("to_rd_zero", rd_data, 32'h0);
        check_value("to_done_stall", {31'd0, stall}, 32'd0);
        check_value("to_done_pulse", {31'd0, timeout_err}, 32'd0);
        tick();
        sample();
        check_value("to_idle_stall", {31'd0, stall}, 32'd0);
        check_value("to_idle_valid", {31'd0, bus_req_valid}, 32'd0);
        check_value("sb_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
